// File: rtl/i_mem_loader.sv
// i_mem_loader: framed byte-stream boot loader for the 32-bit instruction memory, holding the CPU in reset while loading.
// Define I_MEM_LOADER_CHECKSUM_EN to expect a sum-mod-256 trailer byte after the last word.
module i_mem_loader #(
  parameter int         ADDR_W        = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter bit         BOOT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {S_SYNC, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_q, cpu_d;
  logic [ADDR_W:0] wl_q, wl_d;
`ifdef I_MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif
  logic take;
  assign rx_ready     = state_q != S_WRITE;
  assign take         = rx_valid && rx_ready;
  assign mem_we       = state_q == S_WRITE;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_rst_n    = cpu_q;
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wl_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    cpu_d   = cpu_q;
    wl_d    = wl_q;
`ifdef I_MEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_SYNC, S_DONE, S_ERROR: if (take && rx_data == SYNC_BYTE) begin
        state_d = S_COUNT;
        cpu_d   = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wl_d    = '0;
        addr_d  = '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      S_COUNT: if (take) begin
        cnt_d   = rx_data[ADDR_W-1:0];
        idx_d   = 2'd0;
        state_d = S_DATA;
      end
      S_DATA: if (take) begin
        wdata_d[8*idx_q +: 8] = rx_data;
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? S_WRITE : S_DATA;
`ifdef I_MEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + rx_data;
`endif
      end
      S_WRITE: begin
        wl_d = wl_q + 1'b1;
        if (addr_q == cnt_q) begin
`ifdef I_MEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cpu_d   = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_DATA;
        end
      end
`ifdef I_MEM_LOADER_CHECKSUM_EN
      S_CHECK: if (take) begin
        busy_d  = 1'b0;
        state_d = rx_data == sum_q ? S_DONE : S_ERROR;
        done_d  = rx_data == sum_q;
        err_d   = rx_data != sum_q;
        cpu_d   = rx_data == sum_q;
      end
`endif
      default: state_d = S_SYNC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cpu_q   <= !BOOT_ON_RESET;
      wl_q    <= '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cpu_q   <= cpu_d;
      wl_q    <= wl_d;
`ifdef I_MEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_i_mem_loader.sv
// tb_i_mem_loader: directed self-checking bench for i_mem_loader (default parameters).
module tb_i_mem_loader;
  logic clk = 1'b0;
  logic rst_n, rx_valid, rx_ready, mem_we, cpu_rst_n, load_busy, load_done, load_err;
  logic [7:0] rx_data, mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0] words_loaded;
  int errors = 0, checks = 0, wr_cnt = 0, ready_bad = 0;
  logic stall_seen;
  logic [7:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [31:0] img [2] = '{32'h00000293, 32'h02102283};
  logic [7:0] frm [11] = '{8'hA5, 8'h01, 8'h93, 8'h02, 8'h00, 8'h00, 8'h83, 8'h22, 8'h10, 8'h02, 8'h4C};
`ifdef I_MEM_LOADER_CHECKSUM_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  i_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) begin
    wr_addr[wr_cnt % 64] = mem_addr;
    wr_data[wr_cnt % 64] = mem_wdata;
    wr_cnt++;
    if (rx_ready) ready_bad++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 16) begin
      stall_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n == 16) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chk);
    for (int i = 0; i < FL; i++) send_byte(i == 10 ? chk : frm[i]);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_rst_n, rx_ready, mem_we, load_done, load_err, load_busy} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_flags: cpu,rdy,we,done,err,busy=%b required 010000",
               {cpu_rst_n, rx_ready, mem_we, load_done, load_err, load_busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h wdata=%h wl=%0d required 0", mem_addr, mem_wdata, words_loaded);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_rst_n !== 1'b0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL reset_release: cpu_rst_n=%b strobes=%0d required 0 0", cpu_rst_n, wr_cnt);
    end
  endtask

  task automatic test_load;
    int base;
    base = wr_cnt;
    send_byte(8'hA5);
    checks++;
    if ({load_busy, cpu_rst_n, words_loaded} !== {2'b10, 9'd0}) begin
      errors++;
      $display("FAIL load_sync: busy=%b cpu=%b wl=%0d required 1 0 0", load_busy, cpu_rst_n, words_loaded);
    end
    for (int i = 1; i < FL; i++) send_byte(i == 10 ? 8'h4C : frm[i]);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt - base !== 2) begin
      errors++;
      $display("FAIL load_strobes: got %0d required 2", wr_cnt - base);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_addr[(base + i) % 64] !== 8'(i) || wr_data[(base + i) % 64] !== img[i]) begin
        errors++;
        $display("FAIL load_write%0d: @%h=%h required @%h=%h", i, wr_addr[(base + i) % 64],
                 wr_data[(base + i) % 64], 8'(i), img[i]);
      end
    end
    checks++;
    if ({load_done, load_err, load_busy, cpu_rst_n, words_loaded} !== {4'b1001, 9'd2}) begin
      errors++;
      $display("FAIL load_status: done,err,busy,cpu=%b wl=%0d required 1001 2",
               {load_done, load_err, load_busy, cpu_rst_n}, words_loaded);
    end
  endtask

  task automatic test_garbage;
    int base;
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    checks++;
    if ({load_done, load_busy, cpu_rst_n} !== 3'b101) begin
      errors++;
      $display("FAIL garbage_ignored: done,busy,cpu=%b required 101", {load_done, load_busy, cpu_rst_n});
    end
    send_frame(8'h4C);
    checks++;
    if (wr_cnt - base !== 2 || wr_data[base % 64] !== img[0] || wr_data[(base + 1) % 64] !== img[1]) begin
      errors++;
      $display("FAIL garbage_writes: n=%0d d0=%h d1=%h required 2 %h %h", wr_cnt - base,
               wr_data[base % 64], wr_data[(base + 1) % 64], img[0], img[1]);
    end
    checks++;
    if ({load_done, load_err, cpu_rst_n, words_loaded} !== {3'b101, 9'd2}) begin
      errors++;
      $display("FAIL garbage_status: done,err,cpu=%b wl=%0d required 101 2",
               {load_done, load_err, cpu_rst_n}, words_loaded);
    end
  endtask

`ifdef I_MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int base;
    base = wr_cnt;
    send_frame(8'h4D);
    checks++;
    if (wr_cnt - base !== 2 || {load_err, load_done, cpu_rst_n, load_busy} !== 4'b1000) begin
      errors++;
      $display("FAIL checksum_bad: n=%0d err,done,cpu,busy=%b required 2 1000", wr_cnt - base,
               {load_err, load_done, cpu_rst_n, load_busy});
    end
    send_frame(8'h4C);
    checks++;
    if ({load_err, load_done, cpu_rst_n} !== 3'b011) begin
      errors++;
      $display("FAIL checksum_retry: err,done,cpu=%b required 011", {load_err, load_done, cpu_rst_n});
    end
  endtask
`endif

  task automatic test_midreset;
    int base;
    base = wr_cnt;
    for (int i = 0; i < 4; i++) send_byte(frm[i]);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_rst_n, load_busy, load_done, load_err, mem_we, mem_addr, mem_wdata, words_loaded} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: cpu=%b busy=%b done=%b err=%b we=%b addr=%h wdata=%h wl=%0d required all 0",
               cpu_rst_n, load_busy, load_done, load_err, mem_we, mem_addr, mem_wdata, words_loaded);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_cnt - base !== 0) begin
      errors++;
      $display("FAIL midreset_nowrite: strobes=%0d required 0", wr_cnt - base);
    end
    send_frame(8'h4C);
    checks++;
    if (wr_cnt - base !== 2 || wr_addr[(base + 1) % 64] !== 8'd1 || wr_data[(base + 1) % 64] !== img[1]
        || {load_done, cpu_rst_n, words_loaded} !== {2'b11, 9'd2}) begin
      errors++;
      $display("FAIL midreset_reload: n=%0d a1=%h d1=%h done=%b cpu=%b wl=%0d required 2 01 %h 1 1 2",
               wr_cnt - base, wr_addr[(base + 1) % 64], wr_data[(base + 1) % 64], load_done, cpu_rst_n,
               words_loaded, img[1]);
    end
  endtask

  task automatic test_stall;
    int base;
    base = wr_cnt;
    stall_seen = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i % 2 == 1) begin @(posedge clk); #1; end
      send_byte(i == 10 ? 8'h4C : frm[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stall_seen !== 1'b1 || ready_bad !== 0) begin
      errors++;
      $display("FAIL stall_ready: held=%b ready_during_write=%0d required 1 0", stall_seen, ready_bad);
    end
    checks++;
    if (wr_cnt - base !== 2 || wr_data[base % 64] !== img[0] || wr_data[(base + 1) % 64] !== img[1]
        || wr_addr[(base + 1) % 64] !== 8'd1) begin
      errors++;
      $display("FAIL stall_writes: n=%0d d0=%h d1=%h a1=%h required 2 %h %h 01", wr_cnt - base,
               wr_data[base % 64], wr_data[(base + 1) % 64], wr_addr[(base + 1) % 64], img[0], img[1]);
    end
    checks++;
    if ({load_done, load_busy, cpu_rst_n, words_loaded} !== {3'b101, 9'd2}) begin
      errors++;
      $display("FAIL stall_status: done,busy,cpu=%b wl=%0d required 101 2",
               {load_done, load_busy, cpu_rst_n}, words_loaded);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_garbage;
`ifdef I_MEM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    test_midreset;
    test_stall;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end
endmodule
